mips_register_write_arbiter: RTL

Shares the register file's single write port between the in-order pipeline writeback and the long-latency unit (mul/div, loads from the slow path). The block sits directly in front of `Mips_Register_registers` and drives its `wrAddr`/`wrData`/`wrEnable`. It keeps a per-register pending scoreboard so that issue stalls on RAW and WAW hazards against outstanding long ops. It also guarantees that long results are never starved by continuous pipeline writebacks.

---
 rtl/mips_register_write_arbiter_pkg.sv | 32 +++
 rtl/mips_register_write_arbiter_result_queue.sv | 62 ++++++
 rtl/mips_register_write_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mips_register_write_arbiter_pkg.sv
// Shared definitions for the register write-port arbiter: scoreboard width,
// drain FSM encoding, starvation default and a small queue-occupancy helper.
package mips_register_write_arbiter_pkg;

  // Default number of architectural registers (width of the pending vector).
  localparam int PENDING_W = 32;

  // Default number of consecutive blocked cycles before a long result
  // takes the write port away from the pipeline.
  localparam int DEFAULT_STARVE = 4;

  // Drain FSM on the result-queue head.
  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_WAIT  = 2'd1,
    DRAIN_FORCE = 2'd2
  } drain_state_t;

  // Occupancy of the 2-entry result queue, derived from its full/empty flags.
  function automatic logic [1:0] queue_occupancy(input logic full, input logic empty);
    logic [1:0] occ;
    if (full) begin
      occ = 2'd2;
    end else if (empty) begin
      occ = 2'd0;
    end else begin
      occ = 2'd1;
    end
    return occ;
  endfunction

endpackage

// File: rtl/mips_register_write_arbiter_result_queue.sv
// Two-entry {addr, data} FIFO holding long-unit results until the write port
// is free. A pop in the same cycle as a push is allowed; a push into a full
// queue is ignored (the producer only pushes when not full).
module mips_register_write_arbiter_result_queue
  import mips_register_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] addr_mem [2];
  logic [DATA_W-1:0] data_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards any queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/mips_register_write_arbiter.sv
// Shares the register file's single write port between pipeline writeback and
// the long-latency unit. Tracks outstanding long destinations in a pending
// scoreboard (issue stalls on RAW/WAW) and forces queued long results onto the
// port after STARVE blocked cycles so they cannot be starved.
module mips_register_write_arbiter
  import mips_register_write_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_L = PENDING_W,
  parameter int ADDR_W = $clog2(ADDR_L),
  parameter int STARVE = DEFAULT_STARVE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbValid,
  input  logic [ADDR_W-1:0] wbAddr,
  input  logic [DATA_W-1:0] wbData,
  output logic              wbStall,
  input  logic              lngValid,
  input  logic [ADDR_W-1:0] lngAddr,
  input  logic [DATA_W-1:0] lngData,
  output logic              lngReady,
  input  logic              issueLong,
  input  logic [ADDR_W-1:0] issueDst,
  input  logic [ADDR_W-1:0] issueSrc1,
  input  logic [ADDR_W-1:0] issueSrc2,
  output logic              issueStall,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              wrEnable,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE + 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [ADDR_L-1:0] pending;
  logic [ADDR_L-1:0] pending_set;
  logic [ADDR_L-1:0] pending_clr;
  drain_state_t      state;
  drain_state_t      state_next;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_cnt_next;
  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic              q_empty;
  logic [ADDR_W-1:0] q_head_addr;
  logic [DATA_W-1:0] q_head_data;
  logic [1:0]        occ_next;
  logic              issue_accept;
  logic              sel_valid;

  assign lngReady = !q_full && !rst;
  assign q_push   = lngValid && lngReady;
  assign busy     = (|pending) || !q_empty;

  mips_register_write_arbiter_result_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_result_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_addr (lngAddr),
    .push_data (lngData),
    .pop       (q_pop),
    .head_addr (q_head_addr),
    .head_data (q_head_data),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Hazard check against the registered scoreboard; register 0 never stalls.
  always_comb begin
    issueStall = 1'b0;
    if (rst) begin
      issueStall = 1'b0;
    end else begin
      issueStall = ((issueSrc1 != ADDR_ZERO) && pending[issueSrc1])
                || ((issueSrc2 != ADDR_ZERO) && pending[issueSrc2])
                || ((issueDst  != ADDR_ZERO) && pending[issueDst]);
    end
  end

  assign issue_accept = issueLong && !issueStall && (issueDst != ADDR_ZERO);

  // Scoreboard set on accepted long issue, clear when the queue head is written.
  always_comb begin
    pending_set = {ADDR_L{1'b0}};
    pending_clr = {ADDR_L{1'b0}};
    for (int i = 0; i < ADDR_L; i++) begin
      pending_set[i] = issue_accept && (issueDst == ADDR_W'(i));
      pending_clr[i] = q_pop && (q_head_addr == ADDR_W'(i));
    end
  end

  // Drain FSM next state: pop when forced or when the pipeline leaves the port free.
  always_comb begin
    q_pop           = !q_empty && ((state == DRAIN_FORCE) || !wbValid);
    occ_next        = queue_occupancy(q_full, q_empty) + {1'b0, q_push} - {1'b0, q_pop};
    state_next      = state;
    starve_cnt_next = starve_cnt;
    if (q_pop) begin
      starve_cnt_next = {CNT_W{1'b0}};
      state_next      = (occ_next != 2'd0) ? DRAIN_WAIT : DRAIN_IDLE;
    end else if (!q_empty) begin
      starve_cnt_next = starve_cnt + CNT_W'(1);
      state_next      = (starve_cnt == CNT_W'(STARVE - 1)) ? DRAIN_FORCE : DRAIN_WAIT;
    end else begin
      starve_cnt_next = {CNT_W{1'b0}};
      state_next      = q_push ? DRAIN_WAIT : DRAIN_IDLE;
    end
  end

  // Write-port mux: pipeline wins except in FORCE, where it is held off.
  always_comb begin
    wrAddr    = wbAddr;
    wrData    = wbData;
    sel_valid = 1'b0;
    wbStall   = 1'b0;
    if (rst) begin
      sel_valid = 1'b0;
    end else begin
      case (state)
        DRAIN_FORCE: begin
          wrAddr    = q_head_addr;
          wrData    = q_head_data;
          sel_valid = 1'b1;
          wbStall   = 1'b1;
        end
        DRAIN_IDLE, DRAIN_WAIT: begin
          if (wbValid) begin
            sel_valid = 1'b1;
          end else if (!q_empty) begin
            wrAddr    = q_head_addr;
            wrData    = q_head_data;
            sel_valid = 1'b1;
          end else begin
            sel_valid = 1'b0;
          end
        end
        default: begin
          sel_valid = 1'b0;
        end
      endcase
    end
    wrEnable = sel_valid && (wrAddr != ADDR_ZERO);
  end

  // Scoreboard and drain FSM registers; reset drops everything unwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= {ADDR_L{1'b0}};
      state      <= DRAIN_IDLE;
      starve_cnt <= {CNT_W{1'b0}};
    end else begin
      pending    <= (pending & ~pending_clr) | pending_set;
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

endmodule
